pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It replaces the free-running stage-register enables with the following controls:
- per-stage register enables, plus a PC enable;
- per-stage bubble (flush) strobes;
- load-use hazard stalls;
- a multi-cycle multiply hold in EX;
- squash of younger instructions when a taken branch or jump resolves in MEM.

---
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard inputs and stage controls.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
  logic        enable;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_is_mult;
  logic        mem_redirect;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        stall;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output enable, id_rs1, id_rs2, id_uses_rs2,
    output ex_rd, ex_mem_read, ex_is_mult, mem_redirect,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush,
    input  stall, stall_cnt, flush_cnt
  );

  modport slave (
    input  enable, id_rs1, id_rs2, id_uses_rs2,
    input  ex_rd, ex_mem_read, ex_is_mult, mem_redirect,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush,
    output stall, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to build the stall/redirect perf counters.
module pipeline_hazard_ctrl #(
  parameter int MULT_LATENCY = 3,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    MULT_WAIT = 2'd2
  } state_t;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl, stall}
  localparam logic [8:0] CTL_OFF  = 9'b00000_000_0;
  localparam logic [8:0] CTL_RUN  = 9'b11111_000_0;
  localparam logic [8:0] CTL_LU   = 9'b00111_010_1;
  localparam logic [8:0] CTL_MUL  = 9'b00011_001_1;
  localparam logic [8:0] CTL_REDR = 9'b11111_111_0;

  localparam bit MULT_ON = (MULT_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(MULT_ON ? MULT_LATENCY - 2 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       ctl;
  logic             load_use;
  logic             mult_hit;
  logic             rs1_hit;
  logic             rs2_hit;

  assign rs1_hit  = (hz.ex_rd == hz.id_rs1);
  assign rs2_hit  = hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2);
  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0)
                    && (rs1_hit || rs2_hit);
  assign mult_hit = hz.ex_is_mult && MULT_ON;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.enable) begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (!hz.mem_redirect && !load_use && mult_hit) begin
            state_d = MULT_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
        MULT_WAIT: begin
          if (cnt_q != '0) cnt_d   = cnt_q - CNT_W'(1);
          else             state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset gates outputs so an abandoned multiply emits no strobes.
  always_comb begin
    ctl = CTL_OFF;
    if (!rst && hz.enable) begin
      unique case (state_q)
        RUN: begin
          if (hz.mem_redirect) ctl = CTL_REDR;
          else if (load_use)   ctl = CTL_LU;
          else if (mult_hit)   ctl = CTL_MUL;
          else                 ctl = CTL_RUN;
        end
        MULT_WAIT: ctl = (cnt_q != '0) ? CTL_MUL : CTL_RUN;
        default:   ctl = CTL_OFF;
      endcase
    end
  end

  assign hz.pc_en        = ctl[8];
  assign hz.if_id_en     = ctl[7];
  assign hz.id_ex_en     = ctl[6];
  assign hz.ex_mem_en    = ctl[5];
  assign hz.mem_wb_en    = ctl[4];
  assign hz.if_id_flush  = ctl[3];
  assign hz.id_ex_flush  = ctl[2];
  assign hz.ex_mem_flush = ctl[1];
  assign hz.stall        = ctl[0];

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        redir_ev;

  assign redir_ev = (state_q == RUN) && hz.enable
                    && hz.mem_redirect && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ctl[0] && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir_ev && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table on a latency-3 instance,
// hand sequence on latency-5 and latency-1 instances.
module tb_pipeline_hazard_ctrl;

  localparam logic [8:0] Z   = 9'b00000_000_0;
  localparam logic [8:0] ALL = 9'b11111_000_0;
  localparam logic [8:0] LU  = 9'b00111_010_1;
  localparam logic [8:0] MU  = 9'b00011_001_1;
  localparam logic [8:0] RD  = 9'b11111_111_0;

  typedef struct {
    logic       r;
    logic       e;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       mu;
    logic       rdr;
    logic [8:0] x;
  } vec_t;

  typedef struct {
    logic       r;
    logic       e;
    logic [8:0] x5;
    logic [8:0] x1;
  } seq_t;

  typedef struct {
    string       name;
    int          dut;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       en = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u2 = 1'b0, mr = 1'b0, mu = 1'b0, rdr = 1'b0;

  int checks = 0;
  int errors = 0;
  sb_t sbq[$];
  vec_t tv[$];
  seq_t sq[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if h3 ();
  pipeline_hazard_ctrl_if h5 ();
  pipeline_hazard_ctrl_if h1 ();

  pipeline_hazard_ctrl #(.MULT_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .hz(h3.slave));
  pipeline_hazard_ctrl #(.MULT_LATENCY(5)) u5 (
    .clk(clk), .rst(rst), .hz(h5.slave));
  pipeline_hazard_ctrl #(.MULT_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .hz(h1.slave));

  always_comb begin
    h3.enable = en; h3.id_rs1 = rs1; h3.id_rs2 = rs2;
    h3.id_uses_rs2 = u2; h3.ex_rd = rd; h3.ex_mem_read = mr;
    h3.ex_is_mult = mu; h3.mem_redirect = rdr;
    h5.enable = en; h5.id_rs1 = rs1; h5.id_rs2 = rs2;
    h5.id_uses_rs2 = u2; h5.ex_rd = rd; h5.ex_mem_read = mr;
    h5.ex_is_mult = mu; h5.mem_redirect = rdr;
    h1.enable = en; h1.id_rs1 = rs1; h1.id_rs2 = rs2;
    h1.id_uses_rs2 = u2; h1.ex_rd = rd; h1.ex_mem_read = mr;
    h1.ex_is_mult = mu; h1.mem_redirect = rdr;
  end

  function automatic vec_t mk(logic r, logic e, logic [4:0] a,
                              logic [4:0] b, logic c, logic [4:0] d,
                              logic m, logic ml, logic re,
                              logic [8:0] x);
    vec_t v;
    v.r = r; v.e = e; v.rs1 = a; v.rs2 = b; v.u2 = c;
    v.rd = d; v.mr = m; v.mu = ml; v.rdr = re; v.x = x;
    return v;
  endfunction

  function automatic seq_t ms(logic r, logic e,
                              logic [8:0] a, logic [8:0] b);
    seq_t s;
    s.r = r; s.e = e; s.x5 = a; s.x1 = b;
    return s;
  endfunction

  function automatic logic [31:0] actual(int d, int k);
    logic [31:0] v;
    v = '0;
    case (d)
      0: case (k)
        0: v = {23'd0, h3.pc_en, h3.if_id_en, h3.id_ex_en,
                h3.ex_mem_en, h3.mem_wb_en, h3.if_id_flush,
                h3.id_ex_flush, h3.ex_mem_flush, h3.stall};
        1: v = h3.stall_cnt;
        default: v = h3.flush_cnt;
      endcase
      1: case (k)
        0: v = {23'd0, h5.pc_en, h5.if_id_en, h5.id_ex_en,
                h5.ex_mem_en, h5.mem_wb_en, h5.if_id_flush,
                h5.id_ex_flush, h5.ex_mem_flush, h5.stall};
        1: v = h5.stall_cnt;
        default: v = h5.flush_cnt;
      endcase
      default: case (k)
        0: v = {23'd0, h1.pc_en, h1.if_id_en, h1.id_ex_en,
                h1.ex_mem_en, h1.mem_wb_en, h1.if_id_flush,
                h1.id_ex_flush, h1.ex_mem_flush, h1.stall};
        1: v = h1.stall_cnt;
        default: v = h1.flush_cnt;
      endcase
    endcase
    return v;
  endfunction

  task automatic push(string n, int d, int k, logic [31:0] x);
    sb_t s;
    s.name = n; s.dut = d; s.kind = k; s.exp = x;
    sbq.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    logic [31:0] a;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      a = actual(s.dut, s.kind);
      checks++;
      if (a !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", s.name, a, s.exp);
      end
    end
  endtask

  function automatic logic [31:0] perf(logic [31:0] m);
`ifdef HAZARD_PERF_CNT_EN
    return m;
`else
    return (m & 32'd0);
`endif
  endfunction

  initial begin : main
    logic [31:0] ms3, mf3, ms5;
    ms3 = '0; mf3 = '0; ms5 = '0;

    tv.push_back(mk(1,0, 0,0,0, 0,0,0,0, Z));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, Z));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,0, Z));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,0, ALL));
    tv.push_back(mk(0,1, 5,0,0, 5,1,0,0, LU));
    tv.push_back(mk(0,1, 5,0,0, 5,0,0,0, ALL));
    tv.push_back(mk(0,1, 0,0,0, 0,1,0,0, ALL));
    tv.push_back(mk(0,1, 1,5,0, 5,1,0,0, ALL));
    tv.push_back(mk(0,1, 1,5,1, 5,1,0,0, LU));
    tv.push_back(mk(0,1, 0,0,0, 0,0,1,0, MU));
    tv.push_back(mk(0,1, 0,0,0, 0,0,1,0, MU));
    tv.push_back(mk(0,1, 0,0,0, 0,0,1,0, ALL));
    tv.push_back(mk(0,1, 0,0,0, 0,0,1,0, MU));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,0, MU));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,0, ALL));
    tv.push_back(mk(0,1, 5,0,0, 5,1,1,1, RD));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,0, ALL));
    tv.push_back(mk(0,1, 0,0,0, 0,0,1,0, MU));
    tv.push_back(mk(0,0, 0,0,0, 0,0,1,0, Z));
    tv.push_back(mk(0,0, 0,0,0, 0,0,1,0, Z));
    tv.push_back(mk(0,0, 0,0,0, 0,0,1,0, Z));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,1, MU));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,0, ALL));
    tv.push_back(mk(0,1, 0,0,0, 0,0,1,0, MU));
    tv.push_back(mk(1,1, 0,0,0, 0,0,1,0, Z));
    tv.push_back(mk(0,0, 0,0,0, 0,0,1,0, Z));
    tv.push_back(mk(0,1, 0,0,0, 0,0,1,0, Z));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,0, ALL));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,1, Z));
    tv.push_back(mk(0,1, 0,0,0, 0,0,0,0, ALL));

    sq.push_back(ms(1,0, Z,   Z));
    sq.push_back(ms(0,0, Z,   Z));
    sq.push_back(ms(0,1, Z,   Z));
    sq.push_back(ms(0,1, MU,  ALL));
    sq.push_back(ms(0,1, MU,  ALL));
    sq.push_back(ms(0,0, Z,   Z));
    sq.push_back(ms(0,0, Z,   Z));
    sq.push_back(ms(0,0, Z,   Z));
    sq.push_back(ms(0,1, MU,  ALL));
    sq.push_back(ms(0,1, MU,  ALL));
    sq.push_back(ms(0,1, ALL, ALL));
    sq.push_back(ms(0,1, MU,  ALL));

    foreach (tv[i]) begin
      @(posedge clk);
      #1;
      rst = tv[i].r; en = tv[i].e; rs1 = tv[i].rs1;
      rs2 = tv[i].rs2; u2 = tv[i].u2; rd = tv[i].rd;
      mr = tv[i].mr; mu = tv[i].mu; rdr = tv[i].rdr;
      push($sformatf("row%0d ctl", i), 0, 0, {23'd0, tv[i].x});
      push($sformatf("row%0d stall_cnt", i), 0, 1, perf(ms3));
      push($sformatf("row%0d flush_cnt", i), 0, 2, perf(mf3));
      @(negedge clk);
      drain();
      if (tv[i].r) begin
        ms3 = '0; mf3 = '0;
      end else begin
        ms3 += {31'd0, tv[i].x[0]};
        mf3 += (tv[i].x == RD) ? 32'd1 : 32'd0;
      end
    end

    rs1 = '0; rs2 = '0; rd = '0; u2 = 1'b0;
    mr = 1'b0; rdr = 1'b0;
    foreach (sq[i]) begin
      @(posedge clk);
      #1;
      rst = sq[i].r; en = sq[i].e; mu = 1'b1;
      push($sformatf("lat5 step%0d", i), 1, 0, {23'd0, sq[i].x5});
      push($sformatf("lat1 step%0d", i), 2, 0, {23'd0, sq[i].x1});
      @(negedge clk);
      drain();
      if (sq[i].r) ms5 = '0;
      else ms5 += {31'd0, sq[i].x5[0]};
    end

    @(posedge clk);
    #1;
    en = 1'b0; mu = 1'b0;
    push("lat5 stall_cnt", 1, 1, perf(ms5));
    push("lat1 stall_cnt", 2, 1, 32'd0);
    push("lat5 flush_cnt", 1, 2, 32'd0);
    @(negedge clk);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
